imm_ext_arbiter: RTL and testbench
==================================

Name: imm_ext_arbiter

Overview:
- Shares one immediate-extension resource between two requesters: port 0 is decode (I-type operand) and port 1 is the branch/jump target path.
- Each requester presents a 16-bit immediate and an extension mode, and receives a registered 32-bit result with a one-cycle ack.
- Round-robin arbitration with a small FSM makes the single extender time-shared and deterministic.
- Sits between the instruction decode stage and the ALU/PC-update logic.

Parameters:
- IMM_W, 16, immediate input width.
- EXT_W, 32, extended result width. Must be ≥ IMM_W+2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- req0  input  1  port 0 request; held high until ack0.
- imm0  input  IMM_W  port 0 immediate.
- mode0  input  2  port 0 extension mode.
- ack0  output  1  one-cycle pulse: result belongs to port 0.
- req1  input  1  port 1 request; held high until ack1.
- imm1  input  IMM_W  port 1 immediate.
- mode1  input  2  port 1 extension mode.
- ack1  output  1  one-cycle pulse: result belongs to port 1.
- result  output  EXT_W  registered extended value.
- result_valid  output  1  high exactly when ack0 or ack1 is high.
- result_owner  output  1  granted port of the current/last operation.
- busy  output  1  high in states CALC and ACK.

Behaviour:
- Reset (reset_n low at a clock edge):
  - state=IDLE; ack0=ack1=result_valid=busy=0.
  - result=0, result_owner=0, last_grant=1, so port 0 wins the first tie.
- Reset mid-operation: the operation is abandoned and no ack is issued.
- Modes:
  - 00: sign-extend, {replicate imm[IMM_W-1], imm}.
  - 01: zero-extend, {zeros, imm}.
  - 10: upper load, {imm, zeros}, truncated/padded to EXT_W.
  - 11: branch offset, sign-extend then shift left 2; the upper 2 bits of the sign extension are discarded.
- FSM states: IDLE, CALC, ACK.
  - IDLE at cycle N: if any req is high, grant one port.
    - Only one req high: that port is granted.
    - Both high: the port != last_grant is granted.
    - On grant: latch imm/mode of the winner, set result_owner and last_grant, go to CALC.
    - No req: stay in IDLE.
  - CALC (cycle N+1): the extender computes from the latched operands; result is registered at the end of the cycle. Go to ACK.
  - ACK (cycle N+2): result_valid=1 and ack of the owner=1 for exactly this cycle. Go to IDLE.
- Latency and throughput: request sampled at N gives ack at N+2. Maximum throughput is one result per 3 cycles.
- result holds its value until the next CALC completes; it is only meaningful when result_valid=1.
- Requester rule: req must drop no later than cycle N+3. A req still high in IDLE at N+3 is treated as a new request.
- req dropped during CALC/ACK: the operation completes and the ack is still pulsed. A requester that dropped req ignores it.
- imm/mode changes after the grant have no effect; operands are latched.
- The non-granted port's req stays pending. It is served at the next IDLE when last_grant points at the other port, so neither port can starve under continuous contention.
- ack0 and ack1 are never high simultaneously.

Test Plan:
- Reset, then req0=1, imm0=16'h8001, mode0=00 at cycle 0 -> ack0=1 and result=32'hFFFF8001 at cycle 2; busy=1 in cycles 1-2.
- req1=1, imm1=16'h8001, mode1=01 -> result=32'h00008001 with ack1 only; then imm=16'h1234, mode=10 -> 32'h12340000; then imm=16'hFFFF, mode=11 -> 32'hFFFFFFFC.
- req0 and req1 both high continuously from reset -> grant order 0,1,0,1; acks at cycles 2,5,8,11, each on the correct port.
- req0 drops in cycle 1 (CALC) -> ack0 still pulses in cycle 2; no re-grant in cycle 3.
- reset_n low during CALC -> no ack; all outputs 0 next cycle; after release, a req1 is granted normally with port 0 winning the next tie.
- imm0 changed from 16'h0001 to 16'h7FFF one cycle after grant, mode 00 -> result=32'h00000001.

Source files
------------

// File: rtl/imm_ext_if.sv
// Handshake and result bus between the two immediate requesters and the shared extender.
interface imm_ext_if #(
  parameter int unsigned IMM_W = 16,
  parameter int unsigned EXT_W = 32
);
  logic             req0;
  logic [IMM_W-1:0] imm0;
  logic [1:0]       mode0;
  logic             ack0;
  logic             req1;
  logic [IMM_W-1:0] imm1;
  logic [1:0]       mode1;
  logic             ack1;
  logic [EXT_W-1:0] result;
  logic             result_valid;
  logic             result_owner;
  logic             busy;

  // Requester side (decode stage and branch-target path).
  modport master (
    output req0, imm0, mode0, req1, imm1, mode1,
    input  ack0, ack1, result, result_valid, result_owner, busy
  );

  // Arbiter side.
  modport slave (
    input  req0, imm0, mode0, req1, imm1, mode1,
    output ack0, ack1, result, result_valid, result_owner, busy
  );
endinterface

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter time-sharing one immediate extender between two ports.
module imm_ext_arbiter #(
  parameter int unsigned IMM_W = 16,
  parameter int unsigned EXT_W = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  imm_ext_if.slave    bus
);
  localparam int unsigned PAD_W = EXT_W - IMM_W;

  typedef enum logic [1:0] {IDLE, CALC, ACK} state_t;

  state_t           state_q, state_d;
  logic [IMM_W-1:0] imm_q;
  logic [1:0]       mode_q;
  logic             owner_q;
  logic             last_grant_q;
  logic [EXT_W-1:0] result_q;
  logic             ack0_q, ack1_q, valid_q, busy_q;

  logic             take_c;
  logic             grant_c;
  logic [EXT_W-1:0] sext_c;
  logic [EXT_W-1:0] ext_c;

  // Next-state and grant selection; on a tie the port that did not win last time goes.
  always_comb begin
    state_d = state_q;
    take_c  = 1'b0;
    grant_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          take_c  = 1'b1;
          grant_c = ~last_grant_q;
        end else if (bus.req0) begin
          take_c  = 1'b1;
          grant_c = 1'b0;
        end else if (bus.req1) begin
          take_c  = 1'b1;
          grant_c = 1'b1;
        end
        if (take_c) state_d = CALC;
      end
      CALC:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Extender working on the latched operands.
  always_comb begin
    sext_c = {{PAD_W{imm_q[IMM_W-1]}}, imm_q};
    ext_c  = sext_c;
    case (mode_q)
      2'b00:   ext_c = sext_c;
      2'b01:   ext_c = {{PAD_W{1'b0}}, imm_q};
      2'b10:   ext_c = {imm_q, {PAD_W{1'b0}}};
      default: ext_c = {sext_c[EXT_W-3:0], 2'b00};
    endcase
  end

  // State, operand latch, result register and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      imm_q        <= '0;
      mode_q       <= 2'b00;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take_c) begin
        imm_q        <= grant_c ? bus.imm1  : bus.imm0;
        mode_q       <= grant_c ? bus.mode1 : bus.mode0;
        owner_q      <= grant_c;
        last_grant_q <= grant_c;
      end
      if (state_q == CALC) result_q <= ext_c;
      ack0_q  <= (state_d == ACK) && !owner_q;
      ack1_q  <= (state_d == ACK) &&  owner_q;
      valid_q <= (state_d == ACK);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.ack0         = ack0_q;
  assign bus.ack1         = ack1_q;
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.result_owner = owner_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed bench for imm_ext_arbiter with hand-computed expectations.
module tb_imm_ext_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_bad    = 0;

  imm_ext_if #(.IMM_W(16), .EXT_W(32)) bus ();

  imm_ext_arbiter #(.IMM_W(16), .EXT_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single uncontended operation on one port; returns to IDLE afterwards.
  task automatic do_op(input bit port, input logic [15:0] imm, input logic [1:0] mode,
                       input logic [31:0] exp, input string tag);
    if (port) begin
      bus.req1 = 1'b1; bus.imm1 = imm; bus.mode1 = mode;
    end else begin
      bus.req0 = 1'b1; bus.imm0 = imm; bus.mode0 = mode;
    end
    tick();
    check({tag, "_busy_calc"}, 32'(bus.busy), 32'd1);
    check({tag, "_noack_calc"}, 32'({bus.ack1, bus.ack0}), 32'd0);
    tick();
    check({tag, "_ack"}, 32'({bus.ack1, bus.ack0}), port ? 32'd2 : 32'd1);
    check({tag, "_result"}, bus.result, exp);
    check({tag, "_valid"}, 32'(bus.result_valid), 32'd1);
    check({tag, "_owner"}, 32'(bus.result_owner), 32'(port));
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();
    check({tag, "_idle"}, 32'({bus.busy, bus.result_valid, bus.ack1, bus.ack0}), 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.req0  = 1'b0; bus.imm0 = '0; bus.mode0 = 2'b00;
    bus.req1  = 1'b0; bus.imm1 = '0; bus.mode1 = 2'b00;
    tick();
    tick();
    check("rst_outputs", 32'({bus.busy, bus.result_valid, bus.ack1, bus.ack0, bus.result_owner}), 32'd0);
    check("rst_result", bus.result, 32'd0);
    reset_n = 1'b1;

    // Basic sign extension on port 0, then all other modes on port 1.
    do_op(1'b0, 16'h8001, 2'b00, 32'hFFFF8001, "p0_sext");
    do_op(1'b1, 16'h8001, 2'b01, 32'h00008001, "p1_zext");
    do_op(1'b1, 16'h1234, 2'b10, 32'h12340000, "p1_upper");
    do_op(1'b1, 16'hFFFF, 2'b11, 32'hFFFFFFFC, "p1_branch");
    do_op(1'b0, 16'h4001, 2'b11, 32'h00010004, "p0_branch");

    // Continuous contention from reset: grants alternate 0,1,0,1.
    reset_n  = 1'b0;
    bus.req0 = 1'b1; bus.imm0 = 16'h0011; bus.mode0 = 2'b01;
    bus.req1 = 1'b1; bus.imm1 = 16'h0022; bus.mode1 = 2'b01;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      check($sformatf("rr_ack0_c%0d", c), 32'(bus.ack0), 32'((c == 2) || (c == 8)));
      check($sformatf("rr_ack1_c%0d", c), 32'(bus.ack1), 32'((c == 5) || (c == 11)));
      if (c == 2 || c == 8)  check($sformatf("rr_res_c%0d", c), bus.result, 32'h00000011);
      if (c == 5 || c == 11) check($sformatf("rr_res_c%0d", c), bus.result, 32'h00000022);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();

    // req0 dropped during CALC still gets its ack, and is not re-granted.
    bus.req0 = 1'b1; bus.imm0 = 16'h0005; bus.mode0 = 2'b01;
    tick();
    bus.req0 = 1'b0;
    tick();
    check("drop_ack0", 32'({bus.ack1, bus.ack0}), 32'd1);
    check("drop_result", bus.result, 32'h00000005);
    tick();
    check("drop_c3_busy", 32'(bus.busy), 32'd0);
    tick();
    check("drop_c4_busy", 32'(bus.busy), 32'd0);

    // Reset during CALC abandons the operation.
    bus.req0 = 1'b1; bus.imm0 = 16'h00FF; bus.mode0 = 2'b00;
    tick();
    reset_n = 1'b0;
    tick();
    check("midrst_outputs", 32'({bus.busy, bus.result_valid, bus.ack1, bus.ack0, bus.result_owner}), 32'd0);
    check("midrst_result", bus.result, 32'd0);
    bus.req0 = 1'b0;
    reset_n  = 1'b1;
    tick();
    check("midrst_noack", 32'({bus.ack1, bus.ack0}), 32'd0);
    do_op(1'b1, 16'h0002, 2'b01, 32'h00000002, "post_rst_p1");

    // Tie after that: port 0 first, then the pending port 1.
    bus.req0 = 1'b1; bus.imm0 = 16'h0010; bus.mode0 = 2'b01;
    bus.req1 = 1'b1; bus.imm1 = 16'h0020; bus.mode1 = 2'b01;
    tick();
    tick();
    check("tie_first_ack", 32'({bus.ack1, bus.ack0}), 32'd1);
    check("tie_first_res", bus.result, 32'h00000010);
    bus.req0 = 1'b0;
    tick();
    tick();
    tick();
    check("tie_second_ack", 32'({bus.ack1, bus.ack0}), 32'd2);
    check("tie_second_res", bus.result, 32'h00000020);
    bus.req1 = 1'b0;
    tick();

    // Operand change after grant is ignored.
    bus.req0 = 1'b1; bus.imm0 = 16'h0001; bus.mode0 = 2'b00;
    tick();
    bus.imm0 = 16'h7FFF;
    tick();
    check("latch_ack0", 32'(bus.ack0), 32'd1);
    check("latch_result", bus.result, 32'h00000001);
    bus.req0 = 1'b0;
    tick();
    check("latch_hold", bus.result, 32'h00000001);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
